// File: rtl/id_operand_stage.sv
// Decode/operand-fetch stage: 32x32 register file, instruction decode and a registered
// ID/EX boundary with valid/ready flow control, load-use stall and flush.
// Optional macro ID_WB_BYPASS_EN: same-cycle write-back data is forwarded onto operand reads.
module id_operand_stage #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [31:0]       in_instr,
  output logic              in_ready,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [31:0]       ex_instruction,
  output logic [DATA_W-1:0] ex_reg1,
  output logic [DATA_W-1:0] ex_reg2,
  output logic [AW-1:0]     ex_dest,
  output logic              ex_wen,
  output logic              ex_is_load,
  input  logic              flush,
  input  logic              wb_en,
  input  logic [AW-1:0]     wb_addr,
  input  logic [DATA_W-1:0] wb_data
);

  // Handshake: a word moves into ex_* on a cycle where in_valid && in_ready; the ex_*
  // bundle is consumed on a cycle where ex_valid && ex_ready, and holds otherwise.

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_SRA = 6'b000011;

  logic [DATA_W-1:0] regs_q [NREGS];

  logic              ex_valid_q, ex_valid_d;
  logic [31:0]       ex_instr_q, ex_instr_d;
  logic [DATA_W-1:0] ex_reg1_q, ex_reg1_d;
  logic [DATA_W-1:0] ex_reg2_q, ex_reg2_d;
  logic [AW-1:0]     ex_dest_q, ex_dest_d;
  logic              ex_wen_q, ex_wen_d;
  logic              ex_is_load_q, ex_is_load_d;

  logic [5:0]        opcode, funct;
  logic [AW-1:0]     rs_addr, rt_addr, rd_addr;
  logic              reads_rs, reads_rt;
  logic [AW-1:0]     dec_dest;
  logic              dec_wen, dec_is_load;
  logic [DATA_W-1:0] rs_val, rt_val;
  logic              hazard;
  logic              accept;

  assign opcode  = in_instr[31:26];
  assign funct   = in_instr[5:0];
  assign rs_addr = in_instr[25:21];
  assign rt_addr = in_instr[20:16];
  assign rd_addr = in_instr[15:11];

  // Register file: $0 is never written, and reads of it are forced to zero below.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (wb_en && (wb_addr != '0)) begin
      regs_q[wb_addr] <= wb_data;
    end
  end

  always_comb begin
    rs_val = (rs_addr == '0) ? '0 : regs_q[rs_addr];
    rt_val = (rt_addr == '0) ? '0 : regs_q[rt_addr];
`ifdef ID_WB_BYPASS_EN
    if (wb_en && (wb_addr != '0) && (wb_addr == rs_addr)) rs_val = wb_data;
    if (wb_en && (wb_addr != '0) && (wb_addr == rt_addr)) rt_val = wb_data;
`endif
  end

  always_comb begin
    reads_rs    = 1'b0;
    reads_rt    = 1'b0;
    dec_dest    = '0;
    dec_wen     = 1'b0;
    dec_is_load = 1'b0;
    unique case (opcode)
      OP_RTYPE: begin
        dec_dest = rd_addr;
        dec_wen  = (rd_addr != '0);
        reads_rt = 1'b1;
        // Shift-by-immediate forms carry shamt instead of a source register in rs.
        reads_rs = !((funct == FN_SLL) || (funct == FN_SRL) || (funct == FN_SRA));
      end
      OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI, OP_SLTIU, OP_LW: begin
        dec_dest    = rt_addr;
        dec_wen     = (rt_addr != '0);
        reads_rs    = 1'b1;
        dec_is_load = (opcode == OP_LW);
      end
      OP_SW, OP_BEQ, OP_BNE: begin
        reads_rs = 1'b1;
        reads_rt = 1'b1;
      end
      default: ;
    endcase
  end

  assign hazard = ex_valid_q && ex_is_load_q && ex_wen_q && in_valid &&
                  ((reads_rs && (rs_addr == ex_dest_q)) ||
                   (reads_rt && (rt_addr == ex_dest_q)));

  // Flush forces acceptance so the fetched word is swallowed along with the kill.
  assign in_ready = rst_n && (flush || ((!ex_valid_q || ex_ready) && !hazard));
  assign accept   = in_valid && in_ready;

  always_comb begin
    ex_valid_d   = ex_valid_q;
    ex_instr_d   = ex_instr_q;
    ex_reg1_d    = ex_reg1_q;
    ex_reg2_d    = ex_reg2_q;
    ex_dest_d    = ex_dest_q;
    ex_wen_d     = ex_wen_q;
    ex_is_load_d = ex_is_load_q;
    if (flush || (!accept && (ex_ready || !ex_valid_q))) begin
      ex_valid_d   = 1'b0;
      ex_instr_d   = '0;
      ex_reg1_d    = '0;
      ex_reg2_d    = '0;
      ex_dest_d    = '0;
      ex_wen_d     = 1'b0;
      ex_is_load_d = 1'b0;
    end else if (accept) begin
      ex_valid_d   = 1'b1;
      ex_instr_d   = in_instr;
      ex_reg1_d    = rs_val;
      ex_reg2_d    = rt_val;
      ex_dest_d    = dec_dest;
      ex_wen_d     = dec_wen;
      ex_is_load_d = dec_is_load;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q   <= 1'b0;
      ex_instr_q   <= '0;
      ex_reg1_q    <= '0;
      ex_reg2_q    <= '0;
      ex_dest_q    <= '0;
      ex_wen_q     <= 1'b0;
      ex_is_load_q <= 1'b0;
    end else begin
      ex_valid_q   <= ex_valid_d;
      ex_instr_q   <= ex_instr_d;
      ex_reg1_q    <= ex_reg1_d;
      ex_reg2_q    <= ex_reg2_d;
      ex_dest_q    <= ex_dest_d;
      ex_wen_q     <= ex_wen_d;
      ex_is_load_q <= ex_is_load_d;
    end
  end

  assign ex_valid       = ex_valid_q;
  assign ex_instruction = ex_instr_q;
  assign ex_reg1        = ex_reg1_q;
  assign ex_reg2        = ex_reg2_q;
  assign ex_dest        = ex_dest_q;
  assign ex_wen         = ex_wen_q;
  assign ex_is_load     = ex_is_load_q;

endmodule

// File: tb/tb_id_operand_stage.sv
// Directed bench for id_operand_stage; expected operand values follow ID_WB_BYPASS_EN.
module tb_id_operand_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_instr;
  logic        in_ready;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_instruction;
  logic [31:0] ex_reg1;
  logic [31:0] ex_reg2;
  logic [4:0]  ex_dest;
  logic        ex_wen;
  logic        ex_is_load;
  logic        flush;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  int unsigned n_checks;
  int unsigned n_passed;

  id_operand_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_instr       (in_instr),
    .in_ready       (in_ready),
    .ex_valid       (ex_valid),
    .ex_ready       (ex_ready),
    .ex_instruction (ex_instruction),
    .ex_reg1        (ex_reg1),
    .ex_reg2        (ex_reg2),
    .ex_dest        (ex_dest),
    .ex_wen         (ex_wen),
    .ex_is_load     (ex_is_load),
    .flush          (flush),
    .wb_en          (wb_en),
    .wb_addr        (wb_addr),
    .wb_data        (wb_data)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Advance one clock; inputs are then driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    in_valid = 1'b0;
    in_instr = '0;
    flush    = 1'b0;
    wb_en    = 1'b0;
    wb_addr  = '0;
    wb_data  = '0;
  endtask

  task automatic wb_write(input logic [4:0] addr, input logic [31:0] data);
    wb_en   = 1'b1;
    wb_addr = addr;
    wb_data = data;
    tick();
    wb_en   = 1'b0;
  endtask

  task automatic issue(input logic [31:0] instr);
    in_valid = 1'b1;
    in_instr = instr;
    #1;
    check_eq("issue_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  logic [31:0] exp_bypass;

  initial begin
    n_checks = 0;
    n_passed = 0;
    rst_n    = 1'b0;
    ex_ready = 1'b1;
    drive_idle();
    repeat (3) tick();
    check_eq("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check_eq("rst_ex_instr", ex_instruction, 32'h0);
    rst_n = 1'b1;
    tick();

    // Basic operand fetch: add $1,$1,$2
    wb_write(5'd1, 32'h8000_0002);
    wb_write(5'd2, 32'hBFFF_FFFE);
    issue(32'h0022_0820);
    check_eq("add_valid", {31'd0, ex_valid}, 32'd1);
    check_eq("add_reg1", ex_reg1, 32'h8000_0002);
    check_eq("add_reg2", ex_reg2, 32'hBFFF_FFFE);
    check_eq("add_dest", {27'd0, ex_dest}, 32'd1);
    check_eq("add_wen", {31'd0, ex_wen}, 32'd1);
    check_eq("add_instr", ex_instruction, 32'h0022_0820);

    // sw $2,0($1): reads both, no write
    issue(32'hAC22_0000);
    check_eq("sw_wen", {31'd0, ex_wen}, 32'd0);
    check_eq("sw_reg1", ex_reg1, 32'h8000_0002);
    check_eq("sw_reg2", ex_reg2, 32'hBFFF_FFFE);
    tick();
    check_eq("drain_valid", {31'd0, ex_valid}, 32'd0);
    check_eq("drain_zero", ex_instruction, 32'h0);

    // Load-use: lw $3,0($0) then add $4,$3,$0
    issue(32'h8C03_0000);
    check_eq("lw_is_load", {31'd0, ex_is_load}, 32'd1);
    check_eq("lw_dest", {27'd0, ex_dest}, 32'd3);
    in_valid = 1'b1;
    in_instr = 32'h0060_2020;
    #1;
    check_eq("hazard_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    check_eq("bubble_valid", {31'd0, ex_valid}, 32'd0);
    check_eq("bubble_instr", ex_instruction, 32'h0);
    check_eq("after_bubble_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    check_eq("lu_add_valid", {31'd0, ex_valid}, 32'd1);
    check_eq("lu_add_instr", ex_instruction, 32'h0060_2020);
    check_eq("lu_add_dest", {27'd0, ex_dest}, 32'd4);

    // Back-pressure: hold ex_ready low for 3 cycles with addi $7,$0,5 waiting
    ex_ready = 1'b0;
    in_valid = 1'b1;
    in_instr = 32'h2007_0005;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("stall_in_ready", {31'd0, in_ready}, 32'd0);
      tick();
      check_eq("stall_instr", ex_instruction, 32'h0060_2020);
      check_eq("stall_valid", {31'd0, ex_valid}, 32'd1);
    end
    ex_ready = 1'b1;
    #1;
    check_eq("release_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    check_eq("addi_instr", ex_instruction, 32'h2007_0005);
    check_eq("addi_dest", {27'd0, ex_dest}, 32'd7);
    check_eq("addi_is_load", {31'd0, ex_is_load}, 32'd0);

    // Flush with addi in ex_* and ori $8,$0,0xFF presented
    in_valid = 1'b1;
    in_instr = 32'h3408_00FF;
    flush    = 1'b1;
    #1;
    check_eq("flush_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check_eq("flush_valid", {31'd0, ex_valid}, 32'd0);
    check_eq("flush_instr", ex_instruction, 32'h0);
    tick();
    check_eq("ori_gone_valid", {31'd0, ex_valid}, 32'd0);
    check_eq("ori_gone_instr", ex_instruction, 32'h0);

    // Same-cycle write-back of $5 and issue of or $6,$5,$0
`ifdef ID_WB_BYPASS_EN
    exp_bypass = 32'h1234_5678;
`else
    exp_bypass = 32'h0;
`endif
    wb_en   = 1'b1;
    wb_addr = 5'd5;
    wb_data = 32'h1234_5678;
    issue(32'h00A0_3025);
    wb_en = 1'b0;
    check_eq("wb_same_cycle_reg1", ex_reg1, exp_bypass);
    issue(32'h00A0_3025);
    check_eq("wb_later_reg1", ex_reg1, 32'h1234_5678);
    check_eq("or_dest", {27'd0, ex_dest}, 32'd6);

    // Writes to $0 are ignored
    wb_write(5'd0, 32'hFFFF_FFFF);
    issue(32'h0000_4820);
    check_eq("r0_reg1", ex_reg1, 32'h0);
    check_eq("r0_reg2", ex_reg2, 32'h0);

    // Async reset mid-stream, then registers read back as zero
    in_valid = 1'b1;
    in_instr = 32'h0022_0820;
    tick();
    check_eq("pre_rst_valid", {31'd0, ex_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", {31'd0, ex_valid}, 32'd0);
    check_eq("mid_rst_instr", ex_instruction, 32'h0);
    check_eq("mid_rst_reg1", ex_reg1, 32'h0);
    check_eq("mid_rst_dest", {27'd0, ex_dest}, 32'd0);
    check_eq("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    issue(32'h0022_0820);
    check_eq("post_rst_reg1", ex_reg1, 32'h0);
    check_eq("post_rst_reg2", ex_reg2, 32'h0);

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule

// File: doc/id_operand_stage.md
Name: id_operand_stage

Overview:
- Decode/operand-fetch stage that sits directly upstream of the ALU.
- Holds the 32x32 MIPS register file and decodes each incoming instruction word.
- Drives the ALU's instruction, reg1 (rs value) and reg2 (rt value) from a registered ID/EX boundary.
- Provides valid/ready handshakes, load-use stall, flush, and a write-back port.

Parameters:
- DATA_W, 32, register and operand width.
- NREGS, 32, register count; address width is log2(NREGS) = 5.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- in_valid  in  1  fetch presents an instruction.
- in_instr  in  32  instruction word.
- in_ready  out  1  stage accepts in_instr this cycle.
- ex_valid  out  1  ex_* outputs hold a live instruction.
- ex_ready  in  1  ALU/EX accepts ex_* this cycle.
- ex_instruction  out  32  to ALU instruction.
- ex_reg1  out  32  rs value, to ALU reg1.
- ex_reg2  out  32  rt value, to ALU reg2.
- ex_dest  out  5  destination register.
- ex_wen  out  1  instruction writes ex_dest.
- ex_is_load  out  1  opcode 100011 (lw).
- flush  in  1  kill the instruction in this stage and in ex_* (taken branch).
- wb_en  in  1  register write enable.
- wb_addr  in  5  write address.
- wb_data  in  32  write data.

Behaviour:
- Reset (async, rst_n=0):
  - ex_valid, ex_instruction, ex_reg1, ex_reg2, ex_dest, ex_wen and ex_is_load all go to 0.
  - All registers clear to 0.
  - in_ready is 0 while reset is asserted.
  - Reset mid-handshake drops the instruction; no write occurs.
- Register file:
  - Synchronous write on clk when wb_en=1 and wb_addr!=0.
  - $0 always reads 0, and writes to it are ignored.
  - Reads are combinational from in_instr[25:21] (rs) and in_instr[20:16] (rt).
- Decode (opcode = in_instr[31:26], funct = [5:0]):
  - R-type (000000): dest=rd [15:11]; wen=1 iff rd!=0. Reads rt. Reads rs unless funct is sll/srl/sra (000000/000010/000011).
  - addi, addiu, andi, ori, xori, slti, sltiu, lw: dest=rt; wen=1 iff rt!=0; reads rs only.
  - sw, beq, bne: wen=0; read rs and rt.
  - Any other opcode: wen=0, reads none. Passed through unchanged.
- Handshake:
  - Transfer into ex_* occurs when in_valid && in_ready.
  - in_ready = (!ex_valid || ex_ready) && !hazard.
  - If ex_valid && !ex_ready, all ex_* hold stable.
  - If ex_ready=1 and nothing transfers, ex_valid drops to 0 next cycle.
- Load-use hazard:
  - hazard = ex_valid && ex_is_load && ex_wen && in_valid && (incoming reads ex_dest via rs or rt).
  - While hazard holds, in_ready=0; if ex_ready=1, a bubble is issued (ex_valid=0, other ex_* zeroed).
  - Result: exactly one bubble cycle, then the instruction issues.
- Flush:
  - Next cycle ex_valid=0 and ex_* zeroed.
  - in_ready=1 that cycle; any presented instruction is consumed and discarded.
  - Flush overrides stall and hazard.
- Simultaneous write-back and read of the same nonzero register: see WB_BYPASS_EN.
- Latency: one cycle from accepted in_instr to ex_*.

Optional Feature:
- Macro: ID_WB_BYPASS_EN.
- Defined: a read of register r in the same cycle as wb_en && wb_addr==r (r!=0) returns wb_data (write-through).
- Undefined: the read returns the old value. Write-back must then be scheduled one cycle before a dependent issue.

Test Plan:
- Reset, then write $1=0x80000002 and $2=0xBFFFFFFE via wb; issue 0x00220820 (add $1,$1,$2) -> next cycle ex_reg1=0x80000002, ex_reg2=0xBFFFFFFE, ex_dest=1, ex_wen=1, ex_valid=1.
- Issue lw $3,0($0) (0x8C030000), then add $4,$3,$0 (0x00602020) -> in_ready=0 for one cycle and a bubble appears (ex_valid=0); the add issues on the following cycle.
- Hold ex_ready=0 for 3 cycles with an instruction present -> ex_* stable and in_ready=0; release -> the next instruction is accepted.
- Assert flush with addi in ex_* and ori at input -> next cycle ex_valid=0; the ori is consumed and never appears.
- Same-cycle wb $5=0x12345678 and issue of or $6,$5,$0 -> ex_reg1=0x12345678 with ID_WB_BYPASS_EN, 0 without.
- wb_en=1 to $0 with 0xFFFFFFFF, then read $0 -> ex_reg1=0. Deassert rst_n mid-stream -> all ex_* are 0 immediately.
